// File: rtl/fsm_event_counter_pkg.sv
// Shared constants for the detection event counter: active-low seven-segment
// patterns {g..a} and the largest legal BCD digit.
package fsm_event_counter_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Codes 10..15 never occur in a valid count; they blank the digit.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/fsm_event_counter_bcd_to_7seg.sv
// One BCD digit to an active-low seven-segment pattern {g..a}.
module fsm_event_counter_bcd_to_7seg
    import fsm_event_counter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_pattern(bcd);
    end

endmodule

// File: rtl/fsm_event_counter.sv
// Counts detection events from a sequence-detector output in BCD, with sticky
// overflow, a one-cycle event strobe and per-digit seven-segment drive.
module fsm_event_counter
    import fsm_event_counter_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter bit EDGE_MODE = 1'b1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  count_in,
    input  logic                  enable,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  event_out,
    output logic [7*DIGITS-1:0]   seg
);

    logic              prev;
    logic              edge_ok;
    logic              ev;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] at_max;
    logic              wrap;

    // prev tracks count_in unconditionally, so a pulse that starts while
    // enable is low is never counted later in edge mode.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= count_in;
    end

    assign edge_ok  = EDGE_MODE ? ~prev : 1'b1;
    assign ev       = enable & count_in & edge_ok;
    assign carry[0] = ev;
    assign wrap     = carry[DIGITS];

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] digit_q;

            assign at_max[i]   = (digit_q == BCD_MAX_DIGIT);
            assign carry[i+1]  = carry[i] & at_max[i];

            // On overflow every digit is at 9, so wrap mode simply rolls all to 0.
            always_ff @(posedge clock or negedge rst) begin
                if (!rst)
                    digit_q <= 4'd0;
                else if (clr)
                    digit_q <= 4'd0;
                else if (carry[i] && !(SATURATE && wrap))
                    digit_q <= at_max[i] ? 4'd0 : digit_q + 4'd1;
            end

            assign bcd[4*i +: 4] = digit_q;

            fsm_event_counter_bcd_to_7seg u_seg (
                .bcd (digit_q),
                .seg (seg[7*i +: 7])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            event_out <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            event_out <= 1'b0;
        end else begin
            if (wrap) overflow <= 1'b1;
            event_out <= ev;
        end
    end

endmodule

// File: tb/tb_fsm_event_counter.sv
// Bench for fsm_event_counter: three parameter variants against an integer model.
module tb_fsm_event_counter;

    localparam int MAXV = 99;
    localparam bit EDGE_P [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit SAT_P  [3] = '{1'b0, 1'b0, 1'b1};

    logic clock = 1'b0;
    logic rst = 1'b0;
    logic count_in = 1'b0;
    logic enable = 1'b0;
    logic clr = 1'b0;

    logic [7:0]  bcd_o [3];
    logic [13:0] seg_o [3];
    logic        ovf_o [3];
    logic        eo_o  [3];

    int checks = 0;
    int errors = 0;

    int m_cnt [3];
    bit m_ovf [3];
    bit m_eo  [3];
    bit m_prev;

    logic [6:0] seg_tab [10];

    typedef struct {
        logic       ci;
        logic       en;
        logic       cl;
        logic [7:0] bcd;
        logic       eo;
    } vec_t;
    vec_t tbl [13];

    always #10 clock = ~clock;

    fsm_event_counter #(.DIGITS(2), .EDGE_MODE(1'b1), .SATURATE(1'b0)) dut0 (
        .clock(clock), .rst(rst), .count_in(count_in), .enable(enable), .clr(clr),
        .bcd(bcd_o[0]), .overflow(ovf_o[0]), .event_out(eo_o[0]), .seg(seg_o[0]));
    fsm_event_counter #(.DIGITS(2), .EDGE_MODE(1'b0), .SATURATE(1'b0)) dut1 (
        .clock(clock), .rst(rst), .count_in(count_in), .enable(enable), .clr(clr),
        .bcd(bcd_o[1]), .overflow(ovf_o[1]), .event_out(eo_o[1]), .seg(seg_o[1]));
    fsm_event_counter #(.DIGITS(2), .EDGE_MODE(1'b1), .SATURATE(1'b1)) dut2 (
        .clock(clock), .rst(rst), .count_in(count_in), .enable(enable), .clr(clr),
        .bcd(bcd_o[2]), .overflow(ovf_o[2]), .event_out(eo_o[2]), .seg(seg_o[2]));

    // Reference: plain integer count per variant, decoded to BCD only when compared.
    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] <= 0;
                m_ovf[k] <= 1'b0;
                m_eo[k]  <= 1'b0;
            end
            m_prev <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (clr) begin
                    m_cnt[k] <= 0;
                    m_ovf[k] <= 1'b0;
                    m_eo[k]  <= 1'b0;
                end else if (enable && count_in && (!EDGE_P[k] || !m_prev)) begin
                    if (m_cnt[k] == MAXV) begin
                        m_ovf[k] <= 1'b1;
                        m_cnt[k] <= SAT_P[k] ? MAXV : 0;
                    end else begin
                        m_cnt[k] <= m_cnt[k] + 1;
                    end
                    m_eo[k] <= 1'b1;
                end else begin
                    m_eo[k] <= 1'b0;
                end
            end
            m_prev <= count_in;
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s bcd%0d", tag, k), 32'(bcd_o[k]), 32'(to_bcd(m_cnt[k])));
            chk($sformatf("%s ovf%0d", tag, k), 32'(ovf_o[k]), 32'(m_ovf[k]));
            chk($sformatf("%s evo%0d", tag, k), 32'(eo_o[k]), 32'(m_eo[k]));
            chk($sformatf("%s seg%0d", tag, k), 32'(seg_o[k]),
                32'({seg_tab[(m_cnt[k] / 10) % 10], seg_tab[m_cnt[k] % 10]}));
        end
    endtask

    // Called at a negedge: apply inputs, advance one cycle to the next negedge.
    task automatic cyc(input logic ci, input logic en, input logic cl);
        count_in = ci;
        enable   = en;
        clr      = cl;
        @(negedge clock);
    endtask

    task automatic pulses(input int n, input logic en);
        for (int p = 0; p < n; p++) begin
            cyc(1'b1, en, 1'b0);
            cyc(1'b0, en, 1'b0);
        end
    endtask

    initial begin
        int s0;
        int s1;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1};

        // 1: reset state, then idle
        #15;
        chk("reset bcd", 32'(bcd_o[0]), 32'h00);
        chk("reset ovf", 32'(ovf_o[0]), 32'h0);
        chk("reset evo", 32'(eo_o[0]), 32'h0);
        chk("reset seg", 32'(seg_o[0]), 32'h2040);
        @(negedge clock);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1, 1'b0);
        check_all("idle");

        // table of single-cycle vectors against the edge/wrap variant
        cyc(1'b0, 1'b1, 1'b1);
        for (int v = 0; v < 13; v++) begin
            cyc(tbl[v].ci, tbl[v].en, tbl[v].cl);
            chk($sformatf("vec%0d bcd", v), 32'(bcd_o[0]), 32'(tbl[v].bcd));
            chk($sformatf("vec%0d evo", v), 32'(eo_o[0]), 32'(tbl[v].eo));
            check_all($sformatf("vec%0d", v));
        end

        // 2: three short pulses and one 4-cycle pulse
        cyc(1'b0, 1'b1, 1'b1);
        s0 = 0;
        s1 = 0;
        for (int p = 0; p < 4; p++) begin
            for (int h = 0; h < ((p == 3) ? 4 : 1); h++) begin
                cyc(1'b1, 1'b1, 1'b0);
                s0 += int'(eo_o[0]);
                s1 += int'(eo_o[1]);
            end
            cyc(1'b0, 1'b1, 1'b0);
            s0 += int'(eo_o[0]);
            s1 += int'(eo_o[1]);
        end
        chk("pulse bcd edge", 32'(bcd_o[0]), 32'h04);
        chk("pulse bcd level", 32'(bcd_o[1]), 32'h07);
        chk("strobes edge", 32'(s0), 32'd4);
        chk("strobes level", 32'(s1), 32'd7);
        check_all("pulse");

        // 3: reach 99, then overflow in wrap and saturate variants
        cyc(1'b0, 1'b1, 1'b1);
        pulses(99, 1'b1);
        chk("preload 99", 32'(bcd_o[0]), 32'h99);
        cyc(1'b1, 1'b1, 1'b0);
        chk("ovf wrap bcd", 32'(bcd_o[0]), 32'h00);
        chk("ovf wrap flag", 32'(ovf_o[0]), 32'h1);
        chk("ovf wrap evo", 32'(eo_o[0]), 32'h1);
        chk("ovf sat bcd", 32'(bcd_o[2]), 32'h99);
        chk("ovf sat flag", 32'(ovf_o[2]), 32'h1);
        chk("ovf sat evo", 32'(eo_o[2]), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        pulses(3, 1'b1);
        chk("ovf sticky", 32'(ovf_o[0]), 32'h1);
        check_all("ovf");
        cyc(1'b0, 1'b1, 1'b1);
        pulses(9, 1'b1);
        chk("preload 09", 32'(bcd_o[0]), 32'h09);
        pulses(1, 1'b1);
        chk("carry 10", 32'(bcd_o[0]), 32'h10);
        check_all("carry");

        // 4: clr beats a coincident rising edge
        cyc(1'b0, 1'b1, 1'b1);
        pulses(5, 1'b1);
        chk("pre clr", 32'(bcd_o[0]), 32'h05);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr bcd", 32'(bcd_o[0]), 32'h00);
        chk("clr ovf", 32'(ovf_o[0]), 32'h0);
        chk("clr evo", 32'(eo_o[0]), 32'h0);
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b1, 1'b0);
        chk("held after clr", 32'(bcd_o[0]), 32'h00);
        check_all("clr");

        // 5: enable gating
        cyc(1'b0, 1'b1, 1'b0);
        pulses(2, 1'b1);
        pulses(3, 1'b0);
        chk("disabled", 32'(bcd_o[0]), 32'h02);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("late enable", 32'(bcd_o[0]), 32'h02);
        check_all("enable");

        // 6: asynchronous reset in the middle of a long pulse
        cyc(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #5 rst = 1'b0;
        #1;
        chk("async bcd", 32'(bcd_o[0]), 32'h00);
        chk("async ovf", 32'(ovf_o[0]), 32'h0);
        chk("async evo", 32'(eo_o[0]), 32'h0);
        chk("async seg", 32'(seg_o[0]), 32'h2040);
        chk("async bcd level", 32'(bcd_o[1]), 32'h00);
        @(negedge clock);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b1, 1'b0);
        check_all("post rst");

        // randomized traffic against the model
        cyc(1'b0, 1'b1, 1'b1);
        for (int r = 0; r < 600; r++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 127) == 0));
            check_all($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
